mem_access_ctrl: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register. It takes the registered EX/MEM fields and runs the data-memory transaction for loads and stores on a req/ack/rvalid bus.
- It aligns and extends load data, and generates store byte strobes.
- It raises stall_req to hold the EX/MEM register while an access is outstanding.
- It presents registered writeback fields to the MEM/WB side. Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and memory (slave).
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              dreq;
    logic              dwe;
    logic [ADDR_W-1:0] daddr;
    logic [3:0]        dwstrb;
    logic [DATA_W-1:0] dwdata;
    logic              dack;
    logic [DATA_W-1:0] drdata;
    logic              drvalid;

    modport master (
        output dreq, dwe, daddr, dwstrb, dwdata,
        input  dack, drdata, drvalid
    );

    modport slave (
        input  dreq, dwe, daddr, dwstrb, dwdata,
        output dack, drdata, drvalid
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs load/store bus transactions for the EX/MEM entry,
// aligns load data, builds store strobes and registers the writeback fields.
module mem_access_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EXCP_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_inst_valid,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_is_load,
    input  logic                  mem_is_store,
    input  logic [1:0]            mem_size,
    input  logic                  mem_sext,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [DATA_W-1:0]     mem_reg2,
    input  logic                  excp_i,
    input  logic [EXCP_W-1:0]     excp_num_i,
    output logic                  stall_req,
    mem_access_ctrl_if.master     bus,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  excp_o,
    output logic [EXCP_W-1:0]     excp_num_o
);
    localparam int unsigned LP_ALE_BIT = 8;
    localparam logic [EXCP_W-1:0] LP_ALE_MASK = EXCP_W'(1) << LP_ALE_BIT;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_mem_op;
    logic                w_misal;
    logic                w_bypass;
    logic                w_issue;
    logic                w_retire;
    logic [3:0]          w_strb;
    logic [DATA_W-1:0]   w_st_data;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_ld_data;

    // Classify the current entry: memory op, misaligned, or bypass (no bus access)
    always_comb begin
        w_mem_op = mem_is_load | mem_is_store;
        w_misal  = w_mem_op &
                   (((mem_size == 2'd1) & mem_mem_addr[0]) |
                    ((mem_size == 2'd2) & (mem_mem_addr[1:0] != 2'b00)));
        w_bypass = ~w_mem_op | excp_i | w_misal;
    end

    // Store byte strobes and lane-replicated store data; loads carry no strobes
    always_comb begin
        w_strb    = 4'hF;
        w_st_data = mem_reg2;
        case (mem_size)
            2'd0: begin
                w_strb    = 4'b0001 << mem_mem_addr[1:0];
                w_st_data = {(DATA_W/8){mem_reg2[7:0]}};
            end
            2'd1: begin
                w_strb    = 4'b0011 << {mem_mem_addr[1], 1'b0};
                w_st_data = {(DATA_W/16){mem_reg2[15:0]}};
            end
            default: ;
        endcase
        if (!mem_is_store) begin
            w_strb = 4'h0;
        end
    end

    // Load alignment: aligned accesses let one byte-granular shift serve all sizes
    always_comb begin
        w_shifted = bus.drdata >> {mem_mem_addr[1:0], 3'b000};
        case (mem_size)
            2'd0:    w_ld_data = {{(DATA_W-8){mem_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_ld_data = {{(DATA_W-16){mem_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_data = bus.drdata;
        endcase
    end

    // Next-state, retirement and stall decode
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_inst_valid && !flush) begin
                    if (w_bypass) begin
                        w_retire = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.dack) begin
                    if (mem_is_load) begin
                        w_state_nxt = flush ? ST_DRAIN : ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_retire    = mem_inst_valid & ~flush;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.drvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_retire    = mem_inst_valid & ~flush;
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.drvalid) begin
                    w_state_nxt = ST_IDLE;
                end
                // Non-memory entries need no bus, so they keep flowing during drain
                w_retire = mem_inst_valid & ~w_mem_op & ~flush;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        stall_req = mem_inst_valid &
                    ((~w_bypass & ~w_retire) | ((r_state == ST_DRAIN) & w_mem_op));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus request fields: loaded on issue, held until accepted or flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dreq   <= 1'b0;
            bus.dwe    <= 1'b0;
            bus.daddr  <= '0;
            bus.dwstrb <= 4'h0;
            bus.dwdata <= '0;
        end else if (w_issue) begin
            bus.dreq   <= 1'b1;
            bus.dwe    <= mem_is_store;
            bus.daddr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
            bus.dwstrb <= w_strb;
            bus.dwdata <= w_st_data;
        end else if ((r_state == ST_REQ) && (bus.dack || flush)) begin
            bus.dreq <= 1'b0;
            bus.dwe  <= 1'b0;
        end
    end

    // Writeback register: loaded on retirement, valid for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_wd      <= '0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
            excp_o     <= 1'b0;
            excp_num_o <= '0;
        end else begin
            wb_valid <= w_retire;
            if (w_retire) begin
                wb_wd      <= mem_wd;
                wb_wreg    <= mem_wreg & ~w_misal;
                wb_wdata   <= (r_state == ST_WAIT) ? w_ld_data : mem_wdata;
                excp_o     <= excp_i | w_misal;
                excp_num_o <= excp_num_i | (w_misal ? LP_ALE_MASK : '0);
            end else if (flush) begin
                wb_wreg <= 1'b0;
                excp_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed entries push expected bus
// requests and writebacks; a monitor pops and compares when the DUT presents them.
module tb_mem_access_ctrl;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_inst_valid;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic        mem_is_store;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic        excp_i;
    logic [9:0]  excp_num_i;
    logic        stall_req;
    logic        wb_valid;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        excp_o;
    logic [9:0]  excp_num_o;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_inst_valid(mem_inst_valid),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store), .mem_size(mem_size),
        .mem_sext(mem_sext), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .excp_i(excp_i), .excp_num_i(excp_num_i), .stall_req(stall_req), .bus(bus),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .excp_o(excp_o), .excp_num_o(excp_num_o)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        excp;
        logic [9:0]  en;
        int          issue;
        int          lat;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        chk_data;
        int          req_cycles;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int dreq_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare bus requests on acceptance and writebacks when valid
    always @(negedge clk) begin
        bus_exp_t be;
        wb_exp_t  we;
        #2;
        if (bus.dreq === 1'b1) begin
            dreq_run++;
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus_unexpected: dreq=1 daddr=%h with none expected", bus.daddr);
            end else if (bus.dack === 1'b1) begin
                be = bus_q.pop_front();
                chk("daddr", bus.daddr, be.addr);
                chk("dwe", 32'(bus.dwe), 32'(be.we));
                chk("dwstrb", 32'(bus.dwstrb), 32'(be.strb));
                if (be.chk_data) chk("dwdata", bus.dwdata, be.data);
                chk("dreq_cycles", 32'(dreq_run), 32'(be.req_cycles));
                dreq_run = 0;
            end
        end else begin
            dreq_run = 0;
        end
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wb_unexpected: wb_valid=1 wb_wd=%0d with none expected", wb_wd);
            end else begin
                we = wb_q.pop_front();
                chk("wb_wd", 32'(wb_wd), 32'(we.wd));
                chk("wb_wreg", 32'(wb_wreg), 32'(we.wreg));
                chk("wb_wdata", wb_wdata, we.wdata);
                chk("excp_o", 32'(excp_o), 32'(we.excp));
                chk("excp_num_o", 32'(excp_num_o), 32'(we.en));
                chk("latency", 32'(cyc - we.issue), 32'(we.lat));
            end
        end
    end

    // Apply one entry, act as the memory, and hold it until stall_req releases it
    task automatic run_vec(
        input logic ld, input logic st, input logic [1:0] size, input logic sext,
        input logic [31:0] addr, input logic [31:0] reg2, input logic [31:0] wdata,
        input logic [4:0] wd, input logic wreg, input logic ei, input logic [9:0] en,
        input logic [31:0] rd, input int ack_w, input int rv_w,
        input logic exp_bus, input logic [3:0] exp_strb, input logic [31:0] exp_dwdata,
        input logic [31:0] exp_wbdata, input logic exp_wreg, input logic exp_excp,
        input logic [9:0] exp_en, input int exp_lat);
        int cnt = 0;
        int stalls = 0;
        int ph;
        logic stl;
        wb_exp_t  we;
        bus_exp_t be;
        mem_inst_valid = 1'b1; mem_is_load = ld; mem_is_store = st; mem_size = size;
        mem_sext = sext; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = wdata;
        mem_wd = wd; mem_wreg = wreg; excp_i = ei; excp_num_i = en;
        we = '{wd: wd, wreg: exp_wreg, wdata: exp_wbdata, excp: exp_excp, en: exp_en,
               issue: cyc, lat: exp_lat};
        wb_q.push_back(we);
        if (exp_bus) begin
            be = '{addr: addr & 32'hFFFF_FFFC, we: st, strb: exp_strb, data: exp_dwdata,
                   chk_data: st, req_cycles: ack_w + 1};
            bus_q.push_back(be);
        end
        ph = exp_bus ? 1 : 3;
        forever begin
            @(negedge clk);
            if (ph == 1 && bus.dreq === 1'b1) begin
                if (cnt == ack_w) begin
                    bus.dack = 1'b1; ph = ld ? 2 : 3; cnt = 0;
                end else cnt++;
            end else if (ph == 2) begin
                if (cnt == rv_w) begin
                    bus.drvalid = 1'b1; bus.drdata = rd; ph = 3;
                end else cnt++;
            end
            #1;
            stl = stall_req;
            @(posedge clk);
            #1;
            bus.dack = 1'b0;
            bus.drvalid = 1'b0;
            if (stl !== 1'b1) break;
            stalls++;
            if (stalls > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout: entry wd=%0d still stalled after %0d cycles", wd, stalls);
                break;
            end
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_lat - 1));
        mem_inst_valid = 1'b0;
    endtask

    initial begin
        bus_exp_t be;
        wb_exp_t  we;
        rst = 1'b1; flush = 1'b0; mem_inst_valid = 1'b0; mem_wd = '0; mem_wreg = 1'b0;
        mem_wdata = '0; mem_is_load = 1'b0; mem_is_store = 1'b0; mem_size = 2'd0;
        mem_sext = 1'b0; mem_mem_addr = '0; mem_reg2 = '0; excp_i = 1'b0; excp_num_i = '0;
        bus.dack = 1'b0; bus.drvalid = 1'b0; bus.drdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dreq", 32'(bus.dreq), 32'd0);
        chk("rst_dwe", 32'(bus.dwe), 32'd0);
        chk("rst_daddr", bus.daddr, 32'd0);
        chk("rst_dwstrb", 32'(bus.dwstrb), 32'd0);
        chk("rst_dwdata", bus.dwdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_excp_o", 32'(excp_o), 32'd0);
        chk("rst_excp_num_o", 32'(excp_num_o), 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //      ld st sz sx addr         reg2          wdata         wd wr ei en      rd            ak rv bus strb   dwdata        wbdata        wr ex en      lat
        run_vec(0, 0, 2, 0, 32'h0,       32'h0,        32'h1234,     5, 1, 0, 10'h0,  32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h1234,     1, 0, 10'h0,  1);
        run_vec(0, 1, 2, 0, 32'h1000,    32'hDEADBEEF, 32'h1000,     0, 0, 0, 10'h0,  32'h0,        2, 0, 1, 4'hF, 32'hDEADBEEF, 32'h1000,     0, 0, 10'h0,  4);
        run_vec(1, 0, 0, 1, 32'h1003,    32'h0,        32'h0,        7, 1, 0, 10'h0,  32'h80FFFF00, 0, 1, 1, 4'h0, 32'h0,        32'hFFFFFF80, 1, 0, 10'h0,  4);
        run_vec(1, 0, 0, 0, 32'h1003,    32'h0,        32'h0,        8, 1, 0, 10'h0,  32'h80FFFF00, 1, 0, 1, 4'h0, 32'h0,        32'h00000080, 1, 0, 10'h0,  4);
        run_vec(0, 1, 1, 0, 32'h2002,    32'h0000ABCD, 32'h2002,     0, 0, 0, 10'h0,  32'h0,        0, 0, 1, 4'hC, 32'hABCDABCD, 32'h2002,     0, 0, 10'h0,  2);
        run_vec(1, 0, 2, 0, 32'h1002,    32'h0,        32'h55,       3, 1, 0, 10'h003,32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h55,       0, 1, 10'h103,1);
        run_vec(0, 1, 0, 0, 32'h1001,    32'h12345678, 32'h77,       0, 0, 0, 10'h0,  32'h0,        1, 0, 1, 4'h2, 32'h78787878, 32'h77,       0, 0, 10'h0,  3);
        run_vec(1, 0, 1, 1, 32'h2002,    32'h0,        32'h0,        10,1, 0, 10'h0,  32'h80017FFF, 0, 0, 1, 4'h0, 32'h0,        32'hFFFF8001, 1, 0, 10'h0,  3);
        run_vec(1, 0, 1, 0, 32'h2000,    32'h0,        32'h0,        11,1, 0, 10'h0,  32'h8001F00F, 0, 0, 1, 4'h0, 32'h0,        32'h0000F00F, 1, 0, 10'h0,  3);
        run_vec(0, 0, 2, 0, 32'h0,       32'h0,        32'hABCD,     12,1, 1, 10'h040,32'h0,        0, 0, 0, 4'h0, 32'h0,        32'hABCD,     1, 1, 10'h040,1);
        run_vec(1, 0, 2, 0, 32'h4004,    32'h0,        32'h0,        13,1, 0, 10'h0,  32'hCAFEF00D, 2, 2, 1, 4'h0, 32'h0,        32'hCAFEF00D, 1, 0, 10'h0,  7);
        run_vec(0, 1, 1, 0, 32'h2001,    32'hFFFF,     32'h99,       0, 0, 0, 10'h0,  32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h99,       0, 1, 10'h100,1);
        run_vec(1, 0, 2, 0, 32'h5000,    32'h0,        32'h42,       14,1, 1, 10'h004,32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h42,       1, 1, 10'h004,1);

        // Flush while a load waits for data; the next load must wait out the drain
        mem_inst_valid = 1'b1; mem_is_load = 1'b1; mem_is_store = 1'b0; mem_size = 2'd2;
        mem_sext = 1'b0; mem_mem_addr = 32'h3000; mem_wd = 5'd20; mem_wreg = 1'b1;
        mem_wdata = 32'h0; excp_i = 1'b0; excp_num_i = '0;
        be = '{addr: 32'h3000, we: 1'b0, strb: 4'h0, data: 32'h0, chk_data: 1'b0, req_cycles: 1};
        bus_q.push_back(be);
        @(posedge clk); #1;
        @(negedge clk); bus.dack = 1'b1;
        @(posedge clk); #1; bus.dack = 1'b0; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        mem_mem_addr = 32'h3004; mem_wd = 5'd21;
        we = '{wd: 5'd21, wreg: 1'b1, wdata: 32'h11223344, excp: 1'b0, en: 10'h0, issue: cyc, lat: 5};
        wb_q.push_back(we);
        be = '{addr: 32'h3004, we: 1'b0, strb: 4'h0, data: 32'h0, chk_data: 1'b0, req_cycles: 1};
        bus_q.push_back(be);
        @(negedge clk); #1;
        chk("drain_stall_0", 32'(stall_req), 32'd1);
        chk("drain_dreq_0", 32'(bus.dreq), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); bus.drvalid = 1'b1; bus.drdata = 32'hBAADBAAD; #1;
        chk("drain_stall_1", 32'(stall_req), 32'd1);
        chk("drain_dreq_1", 32'(bus.dreq), 32'd0);
        @(posedge clk); #1; bus.drvalid = 1'b0;
        @(negedge clk); #1;
        chk("post_drain_dreq", 32'(bus.dreq), 32'd0);
        chk("post_drain_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reissue_dreq", 32'(bus.dreq), 32'd1);
        bus.dack = 1'b1;
        @(posedge clk); #1; bus.dack = 1'b0;
        @(negedge clk); bus.drvalid = 1'b1; bus.drdata = 32'h11223344;
        @(posedge clk); #1; bus.drvalid = 1'b0; mem_inst_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during an outstanding store drops the request
        mem_inst_valid = 1'b1; mem_is_load = 1'b0; mem_is_store = 1'b1; mem_size = 2'd2;
        mem_mem_addr = 32'h6000; mem_reg2 = 32'h0BADF00D; mem_wd = 5'd0; mem_wreg = 1'b0;
        be = '{addr: 32'h6000, we: 1'b1, strb: 4'hF, data: 32'h0BADF00D, chk_data: 1'b1, req_cycles: 9};
        bus_q.push_back(be);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_dreq", 32'(bus.dreq), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; mem_inst_valid = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_dreq", 32'(bus.dreq), 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        bus_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
